// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a cache miss, fetches one 16-byte block as WORDS
// pipelined 16-bit reads, steers each returned word into the cache data
// array, and writes the tag together with the final data word.
module cache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [IDX_W-1:0]  data_word_idx,
    output logic              write_tag_array
);

    // Counters need one extra bit so that "all WORDS requests issued" is representable.
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [CNT_W-1:0]  req_cnt, req_nxt;
    logic [CNT_W-1:0]  ret_cnt, ret_nxt;

    // The returned word goes straight to the data array outside this block,
    // and the block offset bits of the miss address are discarded by the
    // alignment; both are kept only so the port list matches the wiring.
    logic unused_bits;
    assign unused_bits = ^{memory_data, miss_address[CNT_W-1:0]};

    // State and counter registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            base    <= '0;
            req_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            state   <= state_nxt;
            base    <= base_nxt;
            req_cnt <= req_nxt;
            ret_cnt <= ret_nxt;
        end
    end

    // Next-state, counter updates and all outputs; every output is 0 in IDLE.
    always_comb begin
        state_nxt        = state;
        base_nxt         = base;
        req_nxt          = req_cnt;
        ret_nxt          = ret_cnt;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        data_word_idx    = '0;
        write_tag_array  = 1'b0;

        case (state)
            IDLE: begin
                // Stray memory returns while idle are ignored: nothing here looks at them.
                if (miss_detected) begin
                    state_nxt = FILL;
                    base_nxt  = {miss_address[ADDR_W-1:CNT_W], {CNT_W{1'b0}}};
                    req_nxt   = '0;
                    ret_nxt   = '0;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;

                // Request side: one read per cycle until all WORDS are issued.
                // The address is driven only alongside mem_en, so the
                // past-the-end offset never appears on the bus.
                if (req_cnt < WORDS_C) begin
                    mem_en         = 1'b1;
                    memory_address = base + ADDR_W'({req_cnt, 1'b0});
                    req_nxt        = req_cnt + 1'b1;
                end

                // Return side: words arrive in request order, possibly with gaps.
                write_data_array = memory_data_valid;
                fill_address     = base + ADDR_W'({ret_cnt, 1'b0});
                data_word_idx    = ret_cnt[IDX_W-1:0];
                if (memory_data_valid) begin
                    ret_nxt = ret_cnt + 1'b1;
                    if (ret_cnt == LAST_C) begin
                        write_tag_array = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
